threshold_seq: RTL and testbench

- Frame-level controller that sequences the combinational 8-bit pixel threshold comparator over one image held in a pixel buffer.
- Per pixel, it reads the pixel from the source buffer and presents pixel and threshold to the comparator. It strobes the comparator's active-low evaluate input, captures the binary result and writes it to the destination buffer.
- Sits between the host/config interface and the threshold datapath. It owns buffer addressing, threshold configuration and frame start/done signalling.

---
 rtl/threshold_seq_if.sv | 30 +++
 rtl/threshold_seq.sv | 120 ++++++++++++
 tb/tb_threshold_seq.sv | 316 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/threshold_seq_if.sv
// Buffer and comparator bus between threshold_seq (master) and the pixel
// buffers plus the threshold datapath (slave).
interface threshold_seq_if #(
  parameter int ADDR_W = 14
);
  // Source read: rd_en is held for exactly one cycle, and rd_data is valid the
  // following cycle. Comparator: dp_ready low means evaluate, so dp_result is
  // valid in that same cycle. Destination write: wr_en qualifies wr_addr and
  // wr_data for one cycle. There is no backpressure on any path.
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [7:0]        rd_data;
  logic [7:0]        dp_pix;
  logic [7:0]        dp_thr;
  logic              dp_ready;
  logic [7:0]        dp_result;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;

  modport master (
    output rd_en, rd_addr, dp_pix, dp_thr, dp_ready, wr_en, wr_addr, wr_data,
    input  rd_data, dp_result
  );

  modport slave (
    input  rd_en, rd_addr, dp_pix, dp_thr, dp_ready, wr_en, wr_addr, wr_data,
    output rd_data, dp_result
  );
endinterface

// File: rtl/threshold_seq.sv
// Frame sequencer for the 8-bit pixel threshold comparator: read, evaluate, write, 4 cycles/pixel.
// Optional THRESH_ADAPTIVE_EN: next frame's pending threshold becomes this frame's mean.
module threshold_seq #(
  parameter int         IMG_W       = 128,
  parameter int         IMG_H       = 128,
  parameter int         ADDR_W      = 14,
  parameter logic [7:0] DEFAULT_THR = 8'd128
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               cfg_we,
  input  logic [7:0]         thr_cfg,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_dbg,
  threshold_seq_if.master    bus
);
  localparam logic [ADDR_W-1:0] LAST_PIX = ADDR_W'(IMG_W * IMG_H - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD   = 3'd1,
    S_WT   = 3'd2,
    S_EV   = 3'd3,
    S_WR   = 3'd4,
    S_FIN  = 3'd5
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] cnt;
  logic [7:0]        thr_pend;
  logic [7:0]        thr_act;
`ifdef THRESH_ADAPTIVE_EN
  logic [8+ADDR_W-1:0] acc;
`endif

  assign bus.dp_thr = thr_act;
  assign state_dbg  = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      cnt          <= '0;
      thr_pend     <= DEFAULT_THR;
      thr_act      <= DEFAULT_THR;
      busy         <= 1'b0;
      done         <= 1'b0;
      bus.rd_en    <= 1'b0;
      bus.rd_addr  <= '0;
      bus.dp_pix   <= 8'd0;
      bus.dp_ready <= 1'b1;
      bus.wr_en    <= 1'b0;
      bus.wr_addr  <= '0;
      bus.wr_data  <= 8'd0;
`ifdef THRESH_ADAPTIVE_EN
      acc          <= '0;
`endif
    end else begin
      if (cfg_we) thr_pend <= thr_cfg;
      case (state)
        S_IDLE: begin
          if (start) begin
            // A cfg write in the accept cycle is forwarded into this frame.
            thr_act     <= cfg_we ? thr_cfg : thr_pend;
            cnt         <= '0;
            busy        <= 1'b1;
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= '0;
            state       <= S_RD;
`ifdef THRESH_ADAPTIVE_EN
            acc         <= '0;
`endif
          end
        end
        S_RD: begin
          bus.rd_en <= 1'b0;
          state     <= S_WT;
        end
        S_WT: begin
          bus.dp_pix   <= bus.rd_data;
          bus.dp_ready <= 1'b0;
          state        <= S_EV;
        end
        S_EV: begin
          bus.dp_ready <= 1'b1;
          bus.wr_en    <= 1'b1;
          bus.wr_addr  <= cnt;
          bus.wr_data  <= bus.dp_result;
          state        <= S_WR;
`ifdef THRESH_ADAPTIVE_EN
          acc          <= acc + (8+ADDR_W)'(bus.dp_pix);
`endif
        end
        S_WR: begin
          bus.wr_en <= 1'b0;
          if (cnt == LAST_PIX) begin
            done  <= 1'b1;
            state <= S_FIN;
          end else begin
            cnt         <= cnt + ADDR_W'(1);
            bus.rd_en   <= 1'b1;
            bus.rd_addr <= cnt + ADDR_W'(1);
            state       <= S_RD;
          end
        end
        S_FIN: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
`ifdef THRESH_ADAPTIVE_EN
          // Pixel count is 2^ADDR_W, so the mean is a plain slice.
          if (!cfg_we) thr_pend <= acc[ADDR_W +: 8];
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_threshold_seq.sv
// Directed bench for threshold_seq on a small 8x4 frame, with a frame-level
// model, buffer/comparator models and an expected-write queue.
module tb_threshold_seq;
  localparam int         IMG_W     = 8;
  localparam int         IMG_H     = 4;
  localparam int         ADDR_W    = 5;
  localparam int         N         = IMG_W * IMG_H;
  localparam int         FRAME_CYC = 4 * N + 2;
  localparam logic [7:0] DEF_THR   = 8'd128;

  // clock / reset
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] thr_cfg = 8'd0;
  logic       busy;
  logic       done;
  logic [2:0] state_dbg;

  always #5 clk = ~clk;

  threshold_seq_if #(.ADDR_W(ADDR_W)) bus ();

  threshold_seq #(
    .IMG_W(IMG_W), .IMG_H(IMG_H), .ADDR_W(ADDR_W), .DEFAULT_THR(DEF_THR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_we(cfg_we), .thr_cfg(thr_cfg),
    .busy(busy), .done(done), .state_dbg(state_dbg), .bus(bus)
  );

  // buffers and comparator (comparator holds its last result while dp_ready=1)
  logic [7:0] src [N];
  logic [7:0] dst [N];
  logic [7:0] cmp_hold = 8'h5A;
  logic [7:0] cmp_now;

  assign cmp_now       = (bus.dp_pix > bus.dp_thr) ? 8'hFF : 8'h00;
  assign bus.dp_result = bus.dp_ready ? cmp_hold : cmp_now;

  always @(posedge clk) begin
    if (bus.rd_en) bus.rd_data <= src[bus.rd_addr];
    if (bus.wr_en) dst[bus.wr_addr] <= bus.wr_data;
    if (!bus.dp_ready) cmp_hold <= cmp_now;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // frame-level model: a frame occupies FRAME_CYC-1 cycles after its accept cycle
  logic [7:0]          m_pend = DEF_THR;
  logic [7:0]          m_act = DEF_THR;
  bit                  m_active = 1'b0;
  int                  m_cnt = 0;
  logic [ADDR_W+7:0]   exp_q [$];
  logic [ADDR_W-1:0]   rd_q [$];
`ifdef THRESH_ADAPTIVE_EN
  logic [7:0]          m_mean = 8'd0;
`endif

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pend   = DEF_THR;
      m_act    = DEF_THR;
      m_active = 1'b0;
      m_cnt    = 0;
      exp_q.delete();
      rd_q.delete();
    end else begin
      bit acc_now;
      bit fin_edge;
      acc_now  = start && !m_active;
      fin_edge = 1'b0;
      if (m_active) begin
        m_cnt--;
        if (m_cnt == 0) begin
          m_active = 1'b0;
          fin_edge = 1'b1;
        end
      end
`ifdef THRESH_ADAPTIVE_EN
      if (fin_edge) m_pend = m_mean;
`endif
      if (cfg_we) m_pend = thr_cfg;
      if (acc_now) begin
        int sum;
        sum      = 0;
        m_act    = m_pend;
        m_active = 1'b1;
        m_cnt    = FRAME_CYC - 1;
        for (int i = 0; i < N; i++) begin
          rd_q.push_back(ADDR_W'(i));
          exp_q.push_back({ADDR_W'(i), (src[i] > m_act) ? 8'hFF : 8'h00});
          sum += int'(src[i]);
        end
`ifdef THRESH_ADAPTIVE_EN
        m_mean = 8'(sum / N);
`endif
      end
    end
  end

  // per-cycle compare
  always @(negedge clk) begin
    if (!rst) begin
      check("busy", busy, m_active);
      check("done", done, m_active && m_cnt == 1);
      check("dp_thr", bus.dp_thr, m_act);
      check("rd_wr_overlap", bus.rd_en & bus.wr_en, 1'b0);
      if (bus.rd_en) begin
        check("rd_expected", rd_q.size() != 0, 1'b1);
        if (rd_q.size() != 0) check("rd_addr", bus.rd_addr, rd_q.pop_front());
      end
      if (bus.wr_en) begin
        check("wr_expected", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("wr_addr_data", {bus.wr_addr, bus.wr_data}, exp_q.pop_front());
      end
      if (m_active && m_cnt == 1) check("frame_complete", exp_q.size() + rd_q.size(), 0);
      if (done) done_cnt++;
    end
  end

  // driver tasks
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic write_cfg(input logic [7:0] v);
    cfg_we  = 1'b1;
    thr_cfg = v;
    @(negedge clk);
    cfg_we  = 1'b0;
  endtask

  task automatic fill_const(input logic [7:0] v);
    for (int i = 0; i < N; i++) src[i] = v;
  endtask

  task automatic wait_done(output int k);
    k = 0;
    while (done !== 1'b1 && k < 2 * FRAME_CYC) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int d0;
    for (int i = 0; i < N; i++) begin
      src[i] = 8'd0;
      dst[i] = 8'd0;
    end
    rst = 1'b1;
    tick(2);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_rd_en", bus.rd_en, 1'b0);
    check("rst_wr_en", bus.wr_en, 1'b0);
    check("rst_dp_ready", bus.dp_ready, 1'b1);
    check("rst_dp_pix", bus.dp_pix, 8'h00);
    check("rst_dp_thr", bus.dp_thr, 8'h80);
    rst = 1'b0;
    tick(2);

    // ramp frame at the default threshold
    for (int i = 0; i < N; i++) src[i] = 8'(i * 8);
    pulse_start();
    check("ramp_thr", bus.dp_thr, 8'h80);
    wait_done(k);
    check("frame_len", k + 2, 130);
    check("ramp_dst0", dst[0], 8'h00);
    check("ramp_dst16", dst[16], 8'h00);
    check("ramp_dst17", dst[17], 8'hFF);
    check("ramp_dst31", dst[31], 8'hFF);
    tick(1);
    check("busy_after_done", busy, 1'b0);

    // strictly-greater boundary at 0x10
    write_cfg(8'h10);
    fill_const(8'h10);
    pulse_start();
    wait_done(k);
    check("eq_dst0", dst[0], 8'h00);
    check("eq_dst31", dst[31], 8'h00);
    tick(1);
    write_cfg(8'h10);
    fill_const(8'h11);
    pulse_start();
    wait_done(k);
    check("gt_dst5", dst[5], 8'hFF);
    tick(1);

    // mid-frame cfg write only takes effect on the next frame
    write_cfg(8'h10);
    pulse_start();
    tick(10);
    write_cfg(8'hF0);
    wait_done(k);
    check("midcfg_dst31", dst[31], 8'hFF);
    tick(1);
    pulse_start();
`ifdef THRESH_ADAPTIVE_EN
    check("midcfg_next_thr", bus.dp_thr, 8'h11);
`else
    check("midcfg_next_thr", bus.dp_thr, 8'hF0);
`endif
    wait_done(k);
    check("midcfg_next_dst0", dst[0], 8'h00);
    tick(1);

    // starts while busy and in FIN are dropped; one cycle later is accepted
    d0 = done_cnt;
    pulse_start();
    tick(20);
    pulse_start();
    wait_done(k);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("fin_start_ignored", busy, 1'b0);
    check("one_done_pulse", done_cnt - d0, 1);
    pulse_start();
    check("start_after_fin", busy, 1'b1);
    wait_done(k);
    tick(1);

    // start with a same-cycle cfg write
    start   = 1'b1;
    cfg_we  = 1'b1;
    thr_cfg = 8'h20;
    @(negedge clk);
    start   = 1'b0;
    cfg_we  = 1'b0;
    check("fwd_thr", bus.dp_thr, 8'h20);
    wait_done(k);
    tick(1);

    // reset during EV of pixel 10
    fill_const(8'hFF);
    pulse_start();
    tick(42);
    check("ev_dp_ready", bus.dp_ready, 1'b0);
    #1 rst = 1'b1;
    #1;
    check("abort_busy", busy, 1'b0);
    check("abort_done", done, 1'b0);
    check("abort_rd_en", bus.rd_en, 1'b0);
    check("abort_wr_en", bus.wr_en, 1'b0);
    check("abort_dp_ready", bus.dp_ready, 1'b1);
    check("abort_dp_pix", bus.dp_pix, 8'h00);
    check("abort_rd_addr", bus.rd_addr, 0);
    check("abort_wr_addr", bus.wr_addr, 0);
    check("abort_wr_data", bus.wr_data, 8'h00);
    check("abort_dp_thr", bus.dp_thr, 8'h80);
    @(negedge clk);
    rst = 1'b0;
    check("abort_dst9", dst[9], 8'hFF);
    check("abort_dst10", dst[10], 8'h00);
    d0 = done_cnt;
    tick(5);
    check("abort_no_done", done_cnt - d0, 0);
    for (int i = 0; i < N; i++) src[i] = 8'(i * 8);
    pulse_start();
    check("restart_thr", bus.dp_thr, 8'h80);
    check("restart_rd_addr", bus.rd_addr, 0);
    wait_done(k);
    tick(1);

`ifdef THRESH_ADAPTIVE_EN
    // previous frame's mean becomes the next threshold unless cfg overrides in FIN
    fill_const(8'h40);
    pulse_start();
    wait_done(k);
    tick(1);
    pulse_start();
    check("adapt_mean_thr", bus.dp_thr, 8'h40);
    wait_done(k);
    cfg_we  = 1'b1;
    thr_cfg = 8'h99;
    @(negedge clk);
    cfg_we  = 1'b0;
    pulse_start();
    check("adapt_cfg_prio", bus.dp_thr, 8'h99);
    wait_done(k);
    tick(1);
`endif

    tick(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
